// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   localparam int NSTAGE_DEF = 6;
   localparam int NREQ_DEF   = 4;

   // Entry 0 in the LSBs: requests 0..3 originate in stages 2,2,3,4.
   localparam logic [8*NREQ_DEF-1:0] REQ_STAGE_DEF = {8'd4, 8'd3, 8'd2, 8'd2};

   localparam int STALL_BUS = NSTAGE_DEF;
   typedef logic [STALL_BUS-1:0] stall_bus_t;

endpackage

// File: rtl/pipe_wdog.sv
// Stall-run watchdog plus saturating stalled-cycle counter.
module pipe_wdog
   import pipe_ctrl_pkg::*;
#(
   parameter int WDOG_LIMIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_act,
   input  logic        wdog_clr,
   output logic        stall_timeout,
   output logic [31:0] stall_cycles
);

   localparam logic [15:0] LIM_M1 = 16'(WDOG_LIMIT - 1);

   logic [15:0] run_cnt;
   logic        trip;

   // Trip on the edge that moves the run counter onto WDOG_LIMIT.
   assign trip = stall_act && (run_cnt == LIM_M1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt       <= '0;
         stall_timeout <= 1'b0;
         stall_cycles  <= '0;
      end else begin
         if (!stall_act)
            run_cnt <= '0;
         else if (run_cnt != '1)
            run_cnt <= run_cnt + 16'd1;

         if (trip)
            stall_timeout <= 1'b1;
         else if (wdog_clr)
            stall_timeout <= 1'b0;

         if (stall_act && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall decode, flush/redirect FSM, watchdog.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int                    NSTAGE     = NSTAGE_DEF,
   parameter int                    NREQ       = NREQ_DEF,
   parameter logic [8*NREQ-1:0]     REQ_STAGE  = REQ_STAGE_DEF,
   parameter int                    WDOG_LIMIT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   stallreq,
   input  logic              flush_req,
   input  logic [31:0]       flush_pc,
   input  logic              wdog_clr,
   output logic [NSTAGE-1:0] stall,
   output logic [NSTAGE-1:0] flush,
   output logic              new_pc_valid,
   output logic [31:0]       new_pc,
   output logic              stall_timeout,
   output logic [31:0]       stall_cycles
);

   state_t state, state_nxt;

   logic [NREQ-1:0][NSTAGE-1:0] req_mask;
   logic [NSTAGE-1:0]           stall_any;

   // Each request holds its own stage and everything upstream; OR-ing the
   // per-request masks yields stall[0..K] for the deepest requester K.
   for (genvar r = 0; r < NREQ; r++) begin : g_req
      localparam int STG = int'(REQ_STAGE[8*r +: 8]);
      for (genvar s = 0; s < NSTAGE; s++) begin : g_bit
         assign req_mask[r][s] = stallreq[r] && (s <= STG);
      end
   end

   always_comb begin
      stall_any = '0;
      for (int r = 0; r < NREQ; r++)
         stall_any |= req_mask[r];
   end

   assign stall        = (state == FLUSH) ? '0 : stall_any;
   assign flush        = {NSTAGE{state == FLUSH}};
   assign new_pc_valid = (state == FLUSH);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (flush_req)  state_nxt = FLUSH;
         FLUSH:   if (!flush_req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         new_pc <= '0;
      end else begin
         state <= state_nxt;
         if (flush_req)
            new_pc <= flush_pc;
      end
   end

   pipe_wdog #(
      .WDOG_LIMIT (WDOG_LIMIT)
   ) u_wdog (
      .clk           (clk),
      .rst           (rst),
      .stall_act     (stall[0]),
      .wdog_clr      (wdog_clr),
      .stall_timeout (stall_timeout),
      .stall_cycles  (stall_cycles)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

   localparam int NSTAGE = 6;
   localparam int NREQ   = 4;
   // Requests 0..3 map to stages 2,3,4,2 so the directed vectors line up.
   localparam logic [8*NREQ-1:0] REQ_STAGE = {8'd2, 8'd4, 8'd3, 8'd2};

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   stallreq;
   logic              flush_req;
   logic [31:0]       flush_pc;
   logic              wdog_clr;
   logic [NSTAGE-1:0] stall;
   logic [NSTAGE-1:0] flush;
   logic              new_pc_valid;
   logic [31:0]       new_pc;
   logic              stall_timeout;
   logic [31:0]       stall_cycles;

   int n_chk  = 0;
   int n_fail = 0;

   pipe_ctrl #(
      .NSTAGE     (NSTAGE),
      .NREQ       (NREQ),
      .REQ_STAGE  (REQ_STAGE),
      .WDOG_LIMIT (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stallreq      (stallreq),
      .flush_req     (flush_req),
      .flush_pc      (flush_pc),
      .wdog_clr      (wdog_clr),
      .stall         (stall),
      .flush         (flush),
      .new_pc_valid  (new_pc_valid),
      .new_pc        (new_pc),
      .stall_timeout (stall_timeout),
      .stall_cycles  (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; stallreq = '0; flush_req = 1'b0; flush_pc = '0; wdog_clr = 1'b0;
      #2;
      chk("rst_flush",   32'(flush), 32'h0);
      chk("rst_npv",     32'(new_pc_valid), 32'h0);
      chk("rst_newpc",   new_pc, 32'h0);
      chk("rst_tmo",     32'(stall_timeout), 32'h0);
      chk("rst_cycles",  stall_cycles, 32'h0);
      stallreq = 4'b0001; #1;
      chk("rst_stall_comb", 32'(stall), 32'b000111);
      stallreq = '0;
      step(1);
      rst = 1'b0;
      step(1);

      // Stall decode
      stallreq = 4'b0010; #1;
      chk("single_stall", 32'(stall), 32'b001111);
      chk("single_flush", 32'(flush), 32'h0);
      stallreq = 4'b0101; #1;
      chk("prio_stall", 32'(stall), 32'b011111);
      stallreq = 4'b1000; #1;
      chk("req3_stall", 32'(stall), 32'b000111);
      stallreq = 4'b1111; #1;
      chk("all_stall", 32'(stall), 32'b011111);
      stallreq = 4'b0000; #1;
      chk("none_stall", 32'(stall), 32'h0);
      step(1);

      // Single flush with a concurrent stall request
      stallreq = 4'b0001; flush_req = 1'b1; flush_pc = 32'hBFC0_0380; #1;
      chk("fl_same_stall", 32'(stall), 32'b000111);
      chk("fl_same_flush", 32'(flush), 32'h0);
      step(1);
      flush_req = 1'b0; flush_pc = 32'h0;
      chk("fl_flush", 32'(flush), 32'h3F);
      chk("fl_npv",   32'(new_pc_valid), 32'h1);
      chk("fl_newpc", new_pc, 32'hBFC0_0380);
      chk("fl_stall", 32'(stall), 32'h0);
      step(1);
      chk("fl_idle_flush", 32'(flush), 32'h0);
      chk("fl_idle_npv",   32'(new_pc_valid), 32'h0);
      chk("fl_idle_newpc", new_pc, 32'hBFC0_0380);
      chk("fl_idle_stall", 32'(stall), 32'b000111);
      stallreq = '0;

      // Back-to-back flush
      flush_req = 1'b1; flush_pc = 32'h1000_0004;
      step(1);
      chk("b2b_flush_a", 32'(flush), 32'h3F);
      chk("b2b_pc_a",    new_pc, 32'h1000_0004);
      flush_pc = 32'h2000_0008;
      step(1);
      chk("b2b_flush_b", 32'(flush), 32'h3F);
      chk("b2b_pc_b",    new_pc, 32'h2000_0008);
      flush_req = 1'b0;
      step(1);
      chk("b2b_idle",    32'(flush), 32'h0);
      chk("b2b_pc_hold", new_pc, 32'h2000_0008);

      // Fresh counters for the watchdog
      #2 rst = 1'b1; #1;
      chk("rst2_cycles", stall_cycles, 32'h0);
      rst = 1'b0;
      step(1);

      stallreq = 4'b0001;
      step(3);
      chk("wd_pre_tmo", 32'(stall_timeout), 32'h0);
      step(1);
      chk("wd_trip", 32'(stall_timeout), 32'h1);
      chk("wd_cycles", stall_cycles, 32'd4);
      stallreq = '0;
      step(1);
      chk("wd_sticky", 32'(stall_timeout), 32'h1);
      chk("wd_cycles_hold", stall_cycles, 32'd4);
      wdog_clr = 1'b1;
      step(1);
      chk("wd_clr", 32'(stall_timeout), 32'h0);

      // Trip beats clear in the same cycle
      stallreq = 4'b0001;
      step(4);
      chk("wd_trip_wins", 32'(stall_timeout), 32'h1);
      chk("wd_cycles8", stall_cycles, 32'd8);
      stallreq = '0; wdog_clr = 1'b0;

      // Async reset while flushing with the watchdog flag set
      flush_req = 1'b1; flush_pc = 32'hDEAD_BEEF;
      step(1);
      flush_req = 1'b0;
      chk("ar_in_flush", 32'(flush), 32'h3F);
      chk("ar_tmo_set", 32'(stall_timeout), 32'h1);
      #2 rst = 1'b1; #1;
      chk("ar_flush", 32'(flush), 32'h0);
      chk("ar_npv",   32'(new_pc_valid), 32'h0);
      chk("ar_tmo",   32'(stall_timeout), 32'h0);
      chk("ar_newpc", new_pc, 32'h0);
      chk("ar_cycles", stall_cycles, 32'h0);
      rst = 1'b0;
      step(1);

      // A broken stall run restarts the watchdog count
      stallreq = 4'b0001;
      step(3);
      stallreq = '0;
      step(1);
      stallreq = 4'b0001;
      step(3);
      chk("wd_run_reset", 32'(stall_timeout), 32'h0);
      chk("wd_cycles6", stall_cycles, 32'd6);
      step(1);
      chk("wd_run_trip", 32'(stall_timeout), 32'h1);
      stallreq = '0;
      step(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
